// File: rtl/ysyx_040750_npc_pkg.sv
// Shared constants for the next-PC generator: redirect-select bit positions,
// FSM state encoding, reset PC default and the sequential fetch step.
package ysyx_040750_npc_pkg;

  localparam int unsigned SEL_BR     = 0;
  localparam int unsigned SEL_JALR   = 1;
  localparam int unsigned SEL_CSR    = 2;
  localparam int unsigned SEL_FENCEI = 3;

  localparam logic [31:0] RST_PC_DEF = 32'h8000_0000;
  localparam int unsigned INSTR_STEP = 4;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } npc_state_e;

endpackage

// File: rtl/ysyx_040750_npc_tgt.sv
// Redirect target calculation: priority-resolves the select, muxes adder
// operands and produces the target plus a misaligned-target flag.
module ysyx_040750_npc_tgt
  import ysyx_040750_npc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      sel_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] intr_pc_i,
  output logic            hit_o,
  output logic [XLEN-1:0] tgt_o,
  output logic            misalign_o
);

  logic            is_csr, is_fencei, is_jalr;
  logic [XLEN-1:0] op_a, op_b, sum;

  // Multi-hot select resolves csr > fence.i > jalr > br.
  assign is_csr    = sel_i[SEL_CSR];
  assign is_fencei = ~is_csr & sel_i[SEL_FENCEI];
  assign is_jalr   = ~is_csr & ~sel_i[SEL_FENCEI] & sel_i[SEL_JALR];
  assign hit_o     = |sel_i;

  always_comb begin
    op_a = is_fencei ? XLEN'(INSTR_STEP) : imm_i;
    op_b = is_jalr ? rs1_i : redir_pc_i;
    sum  = op_a + op_b;
    if (is_csr) begin
      tgt_o = intr_pc_i;
    end else if (is_jalr) begin
      tgt_o = {sum[XLEN-1:1], 1'b0};
    end else begin
      tgt_o = sum;
    end
  end

  assign misalign_o = ~is_csr & (|tgt_o[1:0]);

endmodule

// File: rtl/ysyx_040750_npc_gen.sv
// Next-PC generator: fetch PC register, redirect hold while IF stalls, epoch tag.
// Optional YSYX_040750_NPC_MISALIGN_EN replaces misaligned targets with I_trap_vec.
module ysyx_040750_npc_gen
  import ysyx_040750_npc_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] RST_PC  = XLEN'(RST_PC_DEF),
  parameter int unsigned     EPOCH_W = 2
) (
  input  logic               I_clk,
  input  logic               I_rst,
  output logic [XLEN-1:0]    O_pc,
  output logic               O_pc_valid,
  input  logic               I_pc_ready,
  output logic [EPOCH_W-1:0] O_epoch,
  input  logic               I_redir_valid,
  input  logic [3:0]         I_redir_sel,
  input  logic [XLEN-1:0]    I_redir_pc,
  input  logic [XLEN-1:0]    I_rs1_data,
  input  logic [XLEN-1:0]    I_imm,
  input  logic [XLEN-1:0]    I_intr_pc,
  input  logic [XLEN-1:0]    I_trap_vec,
  output logic               O_misalign
);

  npc_state_e         state_q;
  logic [XLEN-1:0]    pc_q, pend_pc_q;
  logic               valid_q, pend_valid_q, misalign_q;
  logic [EPOCH_W-1:0] epoch_q;

  logic            sel_hit, tgt_mis, mis_flag, redir, hs;
  logic [XLEN-1:0] tgt_raw, tgt_eff;

  ysyx_040750_npc_tgt #(
    .XLEN(XLEN)
  ) u_tgt (
    .sel_i      (I_redir_sel),
    .redir_pc_i (I_redir_pc),
    .rs1_i      (I_rs1_data),
    .imm_i      (I_imm),
    .intr_pc_i  (I_intr_pc),
    .hit_o      (sel_hit),
    .tgt_o      (tgt_raw),
    .misalign_o (tgt_mis)
  );

`ifdef YSYX_040750_NPC_MISALIGN_EN
  assign mis_flag = tgt_mis;
  assign tgt_eff  = tgt_mis ? I_trap_vec : tgt_raw;
`else
  logic unused_mis;
  assign unused_mis = tgt_mis ^ (^I_trap_vec);
  assign mis_flag   = 1'b0;
  assign tgt_eff    = tgt_raw;
`endif

  // An all-zero select is not a redirect even with I_redir_valid set.
  assign redir = I_redir_valid & sel_hit;
  assign hs    = valid_q & I_pc_ready;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RST_PC;
      pend_pc_q    <= RST_PC;
      valid_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      epoch_q      <= '0;
    end else begin
      valid_q    <= 1'b1;
      misalign_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (redir && (hs || !valid_q)) begin
            pc_q       <= tgt_eff;
            epoch_q    <= epoch_q + EPOCH_W'(1);
            misalign_q <= mis_flag;
          end else if (redir) begin
            // IF is stalled: park the target so O_pc stays stable.
            pend_pc_q    <= tgt_eff;
            pend_valid_q <= 1'b1;
            misalign_q   <= mis_flag;
            state_q      <= ST_HOLD;
          end else if (hs) begin
            pc_q <= pc_q + XLEN'(INSTR_STEP);
          end
        end
        ST_HOLD: begin
          if (hs) begin
            if (redir) begin
              pc_q       <= tgt_eff;
              misalign_q <= mis_flag;
            end else if (pend_valid_q) begin
              pc_q <= pend_pc_q;
            end
            epoch_q      <= epoch_q + EPOCH_W'(1);
            pend_valid_q <= 1'b0;
            state_q      <= ST_RUN;
          end else if (redir) begin
            pend_pc_q  <= tgt_eff;
            misalign_q <= mis_flag;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign O_pc       = pc_q;
  assign O_pc_valid = valid_q;
  assign O_epoch    = epoch_q;
  assign O_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_040750_npc_gen.sv
// Directed self-checking bench for ysyx_040750_npc_gen; expectations follow
// YSYX_040750_NPC_MISALIGN_EN when the bench is built with it.
module tb_ysyx_040750_npc_gen;

`ifdef YSYX_040750_NPC_MISALIGN_EN
  localparam logic [31:0] EXP_JALR = 32'h8000_0800;
  localparam logic [31:0] EXP_BR6  = 32'h8000_0800;
  localparam logic        EXP_MIS  = 1'b1;
`else
  localparam logic [31:0] EXP_JALR = 32'h8000_1002;
  localparam logic [31:0] EXP_BR6  = 32'h8000_0006;
  localparam logic        EXP_MIS  = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] pc;
  logic        pc_valid, pc_ready;
  logic [1:0]  epoch;
  logic        redir_valid;
  logic [3:0]  redir_sel;
  logic [31:0] redir_pc, rs1, imm, intr_pc, trap_vec;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_040750_npc_gen dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .O_pc          (pc),
    .O_pc_valid    (pc_valid),
    .I_pc_ready    (pc_ready),
    .O_epoch       (epoch),
    .I_redir_valid (redir_valid),
    .I_redir_sel   (redir_sel),
    .I_redir_pc    (redir_pc),
    .I_rs1_data    (rs1),
    .I_imm         (imm),
    .I_intr_pc     (intr_pc),
    .I_trap_vec    (trap_vec),
    .O_misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [3:0] sel, input logic [31:0] rpc, input logic [31:0] rimm);
    redir_valid = 1'b1;
    redir_sel   = sel;
    redir_pc    = rpc;
    imm         = rimm;
  endtask

  initial begin
    rst = 1'b1; pc_ready = 1'b0; redir_valid = 1'b0; redir_sel = 4'b0000;
    redir_pc = '0; rs1 = '0; imm = '0; intr_pc = '0; trap_vec = 32'h8000_0800;

    // Reset state
    step(); step();
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    check("rst_epoch", {30'd0, epoch}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    step();
    check("valid_rise", {31'd0, pc_valid}, 32'd1);
    check("first_pc", pc, 32'h8000_0000);

    // Sequential fetch
    pc_ready = 1'b1;
    step(); check("seq_4", pc, 32'h8000_0004);
    step(); check("seq_8", pc, 32'h8000_0008);
    step(); check("seq_c", pc, 32'h8000_000c);
    check("seq_epoch", {30'd0, epoch}, 32'd0);

    // Branch with negative offset
    redirect(4'b0001, 32'h8000_0010, 32'hffff_fff8);
    step(); redir_valid = 1'b0;
    check("br_neg_pc", pc, 32'h8000_0008);
    check("br_neg_epoch", {30'd0, epoch}, 32'd1);

    // Move to 80000020, then jalr while IF stalls
    redirect(4'b0001, 32'h8000_0020, 32'h0);
    step(); redir_valid = 1'b0;
    check("br_20_pc", pc, 32'h8000_0020);
    check("br_20_epoch", {30'd0, epoch}, 32'd2);
    pc_ready = 1'b0;
    rs1 = 32'h8000_1001;
    redirect(4'b0010, 32'h8000_0020, 32'h2);
    step(); redir_valid = 1'b0;
    check("hold_pc", pc, 32'h8000_0020);
    check("hold_epoch", {30'd0, epoch}, 32'd2);
    check("hold_mis", {31'd0, misalign}, {31'd0, EXP_MIS});
    step();
    check("hold_pc2", pc, 32'h8000_0020);
    check("hold_mis_clr", {31'd0, misalign}, 32'd0);
    pc_ready = 1'b1;
    step(); pc_ready = 1'b0;
    check("jalr_pc", pc, EXP_JALR);
    check("jalr_epoch", {30'd0, epoch}, 32'd3);

    // Younger redirect in HOLD wins; epoch bumps once and wraps 3 -> 0
    redirect(4'b0001, 32'h8000_0100, 32'h0);
    step();
    check("hold_br_pc", pc, EXP_JALR);
    intr_pc = 32'h8000_0400;
    redirect(4'b0100, 32'h8000_0100, 32'h0);
    step(); redir_valid = 1'b0;
    check("hold_intr_pc", pc, EXP_JALR);
    check("hold_intr_epoch", {30'd0, epoch}, 32'd3);
    pc_ready = 1'b1;
    step();
    check("intr_pc", pc, 32'h8000_0400);
    check("intr_epoch_wrap", {30'd0, epoch}, 32'd0);

    // fence.i and an epoch sequence of four redirects
    redirect(4'b1000, 32'h8000_0040, 32'h1234);
    step();
    check("fencei_pc", pc, 32'h8000_0044);
    check("ep_seq1", {30'd0, epoch}, 32'd1);
    redirect(4'b0001, 32'h8000_0100, 32'h4);
    step();
    check("br_104_pc", pc, 32'h8000_0104);
    check("ep_seq2", {30'd0, epoch}, 32'd2);
    rs1 = 32'h8000_0200;
    redirect(4'b0010, 32'h8000_0104, 32'h0);
    step();
    check("jalr_200_pc", pc, 32'h8000_0200);
    check("ep_seq3", {30'd0, epoch}, 32'd3);
    intr_pc = 32'h8000_0300;
    redirect(4'b0100, 32'h8000_0200, 32'h0);
    step();
    check("intr_300_pc", pc, 32'h8000_0300);
    check("ep_seq0", {30'd0, epoch}, 32'd0);

    // Multi-hot priority and all-zero select
    intr_pc = 32'h8000_0500;
    redirect(4'b1111, 32'h8000_0600, 32'h10);
    step();
    check("mh_csr_pc", pc, 32'h8000_0500);
    redirect(4'b1010, 32'h8000_0600, 32'h10);
    step();
    check("mh_fencei_pc", pc, 32'h8000_0604);
    check("mh_epoch", {30'd0, epoch}, 32'd2);
    redirect(4'b0000, 32'h8000_0900, 32'h10);
    step(); redir_valid = 1'b0;
    check("zero_sel_pc", pc, 32'h8000_0608);
    check("zero_sel_epoch", {30'd0, epoch}, 32'd2);

    // Misaligned branch target
    redirect(4'b0001, 32'h8000_0000, 32'h6);
    step(); redir_valid = 1'b0;
    check("mis_pc", pc, EXP_BR6);
    check("mis_pulse", {31'd0, misalign}, {31'd0, EXP_MIS});
    check("mis_epoch", {30'd0, epoch}, 32'd3);
    step();
    check("mis_pulse_end", {31'd0, misalign}, 32'd0);
    check("mis_next_pc", pc, EXP_BR6 + 32'd4);

    // pc+4 wraps at the top of the address space
    redirect(4'b0001, 32'hffff_fff0, 32'hc);
    step(); redir_valid = 1'b0;
    check("top_pc", pc, 32'hffff_fffc);
    step();
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset while holding a redirect drops it
    pc_ready = 1'b0;
    redirect(4'b0001, 32'h8000_0000, 32'h100);
    step(); redir_valid = 1'b0;
    check("pre_rst_pc", pc, 32'h0000_0000);
    rst = 1'b1;
    step();
    check("hold_rst_pc", pc, 32'h8000_0000);
    check("hold_rst_valid", {31'd0, pc_valid}, 32'd0);
    check("hold_rst_epoch", {30'd0, epoch}, 32'd0);
    rst = 1'b0; pc_ready = 1'b1;
    step();
    check("post_rst_pc", pc, 32'h8000_0000);
    step();
    check("post_rst_seq", pc, 32'h8000_0004);
    check("post_rst_epoch", {30'd0, epoch}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
